// File: rtl/arm_regfile_mp_if.sv
// Bus bundle for arm_regfile_mp: decode-side read addresses, writeback port,
// debug tap and the Busy flag. The datapath side is the master, the register file is the slave.
interface arm_regfile_mp_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [ADDR_W-1:0] DbgSel;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [DATA_W-1:0] DbgData;
  logic              Busy;

  modport master (
    output ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, DbgSel,
    input  ReadData1, ReadData2, DbgData, Busy
  );

  modport slave (
    input  ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, DbgSel,
    output ReadData1, ReadData2, DbgData, Busy
  );
endinterface

// File: rtl/arm_regfile_mp.sv
// LEGv8 register file with a hardwired XZR, a reset-driven clear sequencer and a debug tap.
// Optional feature macro: RF_BYPASS_EN (write-to-read forwarding on all three read paths).
module arm_regfile_mp #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                clk,
  input  logic                Reset,
  arm_regfile_mp_if.slave     bus
);

  typedef enum logic {CLEAR, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);
  localparam logic [ADDR_W-1:0] XZR_IDX  = ADDR_W'(ZERO_REG);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_next;
  logic              clr_we;
  logic              run_we;
  logic [DATA_W-1:0] rf [NREGS];

  // An address is backed by storage only if it is in range and not XZR.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(NREGS)) && (a != XZR_IDX);
  endfunction

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clr_we     = 1'b0;
    if (state == CLEAR) begin
      clr_we   = 1'b1;
      cnt_next = cnt + 1'b1;
      if (cnt == LAST_IDX) begin
        state_next = RUN;
      end
    end
  end

  assign run_we = (state == RUN) && bus.RegWrite && addr_ok(bus.WriteReg);

  // Reset suppresses both the clear step and any writeback on the same edge.
  always_ff @(posedge clk) begin
    if (!Reset) begin
      if (clr_we) begin
        rf[cnt] <= '0;
      end else if (run_we) begin
        rf[bus.WriteReg] <= bus.WriteData;
      end
    end
  end

  always_comb begin
    bus.ReadData1 = '0;
    bus.ReadData2 = '0;
    bus.DbgData   = '0;
    if (state == RUN) begin
      if (addr_ok(bus.ReadReg1)) bus.ReadData1 = rf[bus.ReadReg1];
      if (addr_ok(bus.ReadReg2)) bus.ReadData2 = rf[bus.ReadReg2];
      if (addr_ok(bus.DbgSel))   bus.DbgData   = rf[bus.DbgSel];
`ifdef RF_BYPASS_EN
      if (run_we && bus.WriteReg == bus.ReadReg1) bus.ReadData1 = bus.WriteData;
      if (run_we && bus.WriteReg == bus.ReadReg2) bus.ReadData2 = bus.WriteData;
      if (run_we && bus.WriteReg == bus.DbgSel)   bus.DbgData   = bus.WriteData;
`endif
    end
  end

  assign bus.Busy = (state == CLEAR);

endmodule

// File: tb/tb_arm_regfile_mp.sv
// Self-checking bench for arm_regfile_mp: directed table, multi-cycle clear/reset sequences
// and randomized traffic checked against an array-based reference model.
module tb_arm_regfile_mp;
  localparam int DATA_W   = 64;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 32;
  localparam int ZERO_REG = 31;

  logic clk = 1'b0;
  logic Reset;

  always #5 clk = ~clk;

  arm_regfile_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  arm_regfile_mp #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS), .ZERO_REG(ZERO_REG)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic              we;
    logic [4:0]        wreg;
    logic [63:0]       wdata;
    logic [4:0]        r1;
    logic [4:0]        r2;
    logic [4:0]        dbg;
    logic [63:0]       e1;
    logic [63:0]       e2;
    logic [63:0]       ed;
  } vec_t;

  logic [63:0] model [NREGS];
  int          clear_left;
  int          n_checks = 0;
  int          n_fail   = 0;
  vec_t        tbl [6];

  // Reference: a reset wipes the whole file at once and blocks access for NREGS edges.
  function automatic logic [63:0] model_read(input logic [4:0] a);
    if (clear_left > 0) return 64'h0;
    if (int'(a) == ZERO_REG || int'(a) >= NREGS) return 64'h0;
`ifdef RF_BYPASS_EN
    if (bus.RegWrite && bus.WriteReg == a) return bus.WriteData;
`endif
    return model[a];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input string tag);
    check({tag, ".rd1"},  bus.ReadData1, model_read(bus.ReadReg1));
    check({tag, ".rd2"},  bus.ReadData2, model_read(bus.ReadReg2));
    check({tag, ".dbg"},  bus.DbgData,   model_read(bus.DbgSel));
    check({tag, ".busy"}, 64'(bus.Busy), 64'(clear_left > 0));
  endtask

  task automatic tick();
    if (Reset) begin
      clear_left = NREGS;
      for (int i = 0; i < NREGS; i++) model[i] = 64'h0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else if (bus.RegWrite && int'(bus.WriteReg) != ZERO_REG && int'(bus.WriteReg) < NREGS) begin
      model[bus.WriteReg] = bus.WriteData;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic we, input logic [4:0] wreg, input logic [63:0] wdata,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    bus.RegWrite  = we;
    bus.WriteReg  = wreg;
    bus.WriteData = wdata;
    bus.ReadReg1  = r1;
    bus.ReadReg2  = r2;
    bus.DbgSel    = dbg;
    #1;
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    while (bus.Busy === 1'b1 && n < 100) begin
      check_output(tag);
      tick();
      n++;
    end
    check({tag, ".clear_len"}, 64'(n), 64'(NREGS));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{1'b1, 5'd3,  64'h0123456789ABCDEF, 5'd0,  5'd1,  5'd2,  64'h0, 64'h0, 64'h0};
    tbl[1] = '{1'b0, 5'd0,  64'h0,                5'd3,  5'd3,  5'd3,
               64'h0123456789ABCDEF, 64'h0123456789ABCDEF, 64'h0123456789ABCDEF};
    tbl[2] = '{1'b1, 5'd31, 64'hFFFF,             5'd3,  5'd30, 5'd30, 64'h0123456789ABCDEF, 64'h0, 64'h0};
    tbl[3] = '{1'b0, 5'd0,  64'h0,                5'd31, 5'd3,  5'd31, 64'h0, 64'h0123456789ABCDEF, 64'h0};
    tbl[4] = '{1'b1, 5'd5,  64'hDEAD,             5'd3,  5'd31, 5'd3,
               64'h0123456789ABCDEF, 64'h0, 64'h0123456789ABCDEF};
    tbl[5] = '{1'b0, 5'd0,  64'h0,                5'd5,  5'd3,  5'd5,  64'hDEAD, 64'h0123456789ABCDEF, 64'hDEAD};

    clear_left = 0;
    for (int i = 0; i < NREGS; i++) model[i] = 64'h0;
    Reset = 1'b1;
    apply_stimulus(1'b0, 5'd0, 64'h0, 5'd0, 5'd0, 5'd0);
    tick();
    Reset = 1'b0;
    check("reset.busy", 64'(bus.Busy), 64'h1);
    wait_clear("init");

    // Directed table; writes land on the following cycle.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(tbl[i].we, tbl[i].wreg, tbl[i].wdata, tbl[i].r1, tbl[i].r2, tbl[i].dbg);
      check($sformatf("tbl%0d.rd1", i), bus.ReadData1, tbl[i].e1);
      check($sformatf("tbl%0d.rd2", i), bus.ReadData2, tbl[i].e2);
      check($sformatf("tbl%0d.dbg", i), bus.DbgData,   tbl[i].ed);
      check_output($sformatf("tbl%0d", i));
      tick();
    end

    // X5 holds 0xDEAD; a one-cycle reset must wipe it after exactly NREGS busy cycles.
    apply_stimulus(1'b0, 5'd0, 64'h0, 5'd5, 5'd3, 5'd5);
    pulse_reset();
    check("clr.busy_after_reset", 64'(bus.Busy), 64'h1);
    check("clr.rd1_during", bus.ReadData1, 64'h0);
    wait_clear("clr");
    check("clr.x5_zero", bus.ReadData1, 64'h0);
    check("clr.x3_zero", bus.ReadData2, 64'h0);

    apply_stimulus(1'b1, 5'd7, 64'h11, 5'd7, 5'd7, 5'd7);
    tick();
    apply_stimulus(1'b1, 5'd7, 64'h22, 5'd7, 5'd0, 5'd7);
`ifdef RF_BYPASS_EN
    check("fwd.same_cycle", bus.ReadData1, 64'h22);
    check("fwd.dbg_same_cycle", bus.DbgData, 64'h22);
`else
    check("fwd.same_cycle", bus.ReadData1, 64'h11);
    check("fwd.dbg_same_cycle", bus.DbgData, 64'h11);
`endif
    check_output("fwd");
    tick();
    apply_stimulus(1'b0, 5'd7, 64'h0, 5'd7, 5'd0, 5'd7);
    check("fwd.next_cycle", bus.ReadData1, 64'h22);

    // Reset again after 10 clear steps: the count restarts from zero.
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      check_output("mid");
      tick();
    end
    check("mid.busy_at10", 64'(bus.Busy), 64'h1);
    pulse_reset();
    wait_clear("mid");

    apply_stimulus(1'b1, 5'd9, 64'h55, 5'd9, 5'd4, 5'd9);
    tick();
    apply_stimulus(1'b0, 5'd9, 64'h0, 5'd9, 5'd4, 5'd9);
    check("wb.x9_preset", bus.ReadData1, 64'h55);
    pulse_reset();
    apply_stimulus(1'b1, 5'd9, 64'hAA, 5'd9, 5'd4, 5'd9);
    wait_clear("wb");
    apply_stimulus(1'b0, 5'd9, 64'h0, 5'd9, 5'd4, 5'd9);
    check("wb.x9_zero", bus.ReadData1, 64'h0);

    apply_stimulus(1'b1, 5'd4, 64'h44, 5'd9, 5'd4, 5'd4);
    tick();
    apply_stimulus(1'b1, 5'd4, 64'h99, 5'd9, 5'd4, 5'd4);
    check("rw.x4_preset", bus.ReadData2, 64'h44);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    apply_stimulus(1'b0, 5'd4, 64'h0, 5'd9, 5'd4, 5'd4);
    wait_clear("rw");
    check("rw.x4_zero", bus.ReadData2, 64'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      Reset = ($urandom_range(0, 149) == 0);
      apply_stimulus(($urandom_range(0, 2) != 0), 5'($urandom_range(0, 31)), {$urandom, $urandom},
                     5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      check_output($sformatf("rnd%0d", i));
      tick();
    end
    Reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
